axis_adc_burst_capture: RTL and testbench
=========================================

Name: axis_adc_burst_capture

Overview:
- Sits directly downstream of the Red Pitaya ADC stage.
- Consumes its 32-bit two-channel sample stream: channel A in [15:0], channel B in [31:16], each a 16-bit signed value.
- Detects the start of an optical OFDM burst by magnitude threshold on one channel, stores a fixed-length frame in internal block RAM, then drains it as an AXI-Stream packet with backpressure to the demodulator/DMA.

Parameters:
- ADDR_WIDTH, 10, log2 of capture buffer depth (1024 samples).
- CHANNEL, 0, 0 selects s_axis_tdata[15:0] (A); 1 selects [31:16] (B).
- CONFIRM, 4, consecutive above-threshold samples required to trigger (1..15).

Ports:
- aclk  input  1  system clock
- aresetn  input  1  asynchronous active-low reset
- s_axis_tvalid  input  1  input sample valid (no tready; stream cannot be stalled)
- s_axis_tdata  input  32  {chB[15:0], chA[15:0]}, signed
- cfg_enable  input  1  arms trigger detection when high
- cfg_threshold  input  15  unsigned magnitude threshold
- cfg_frame_len  input  ADDR_WIDTH+1  samples per frame
- m_axis_tvalid  output  1  output sample valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  16  captured signed sample
- m_axis_tlast  output  1  last sample of frame
- busy  output  1  high in CAPTURE or DRAIN
- frame_count  output  16  completed frames, wraps at 65535->0
- missed_count  output  16  triggers lost during DRAIN, saturates at 65535

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0; confirm counter, write/read pointers and both counters 0.
- Magnitude:
  - mag = |x|; x = -32768 maps to 32767.
  - "Above" means mag > cfg_threshold (strict).
- IDLE:
  - On each s_axis_tvalid cycle with cfg_enable=1: confirm counter increments if above, else clears to 0.
  - cycles without tvalid leave the counter unchanged.
  - When the counter reaches CONFIRM on a valid sample:
    - latch len = cfg_frame_len (0 -> 1; >2^ADDR_WIDTH -> 2^ADDR_WIDTH);
    - that sample is written to address 0;
    - state -> CAPTURE, or directly -> DRAIN if len=1.
  - cfg_enable=0 holds the confirm counter at 0.
- CAPTURE:
  - Each valid sample is written at the next address.
  - When len samples have been written -> DRAIN.
  - cfg_enable and cfg_threshold are ignored once triggered; a frame in progress always completes.
- DRAIN:
  - Synchronous-read RAM plus an output register.
  - First m_axis_tvalid is asserted exactly 2 cycles after the final capture write.
  - Samples are emitted in capture order, addresses 0..len-1.
  - Full throughput: with m_axis_tready held high, one sample per cycle with no bubbles.
  - tdata/tlast are held stable while tvalid=1 and tready=0.
  - tlast=1 only with sample len-1.
  - On the tlast handshake:
    - frame_count increments;
    - state -> IDLE on the next cycle, confirm counter 0;
    - tvalid drops the same cycle as the transfer unless a new frame is ready (it cannot be; see gap).
  - Input samples during DRAIN are discarded.
  - If CONFIRM consecutive above-threshold valid samples occur during DRAIN (cfg_enable=1), missed_count increments once per such run (rising edge of the confirm condition).
- busy = (state != IDLE).
- Reset mid-frame: immediate return to IDLE and outputs 0. The partial frame is lost; it is not emitted after reset.

Test Plan:
- CONFIRM=4, threshold=1000, len=8, channel A: feed 3 samples of 2000, 1 of 500, then ramp 1200,1201,... -> trigger on 4th ramp sample (1203). Output is 1203..1210, tlast on 1210, frame_count=1. The first three ramp samples are not captured.
- Negative and extreme values: samples -32768 repeated with threshold=32766 -> triggers; threshold=32767 -> never triggers, busy stays 0.
- Backpressure: len=16, tready toggled 1,0,0,1 pattern -> 16 transfers in order, data held stable while stalled, exactly one tlast.
- Intermittent s_axis_tvalid (1 of every 3 cycles) during CAPTURE -> only valid samples stored. First m_axis_tvalid comes 2 cycles after the 8th write.
- Large burst during DRAIN with tready=0 for 100 cycles -> missed_count=1, frame_count unchanged until drain finishes. Next trigger is accepted only after returning to IDLE.
- Length and reset edges:
  - len=0 -> single-sample frame with tlast.
  - len=2000 with ADDR_WIDTH=10 -> 1024-sample frame.
  - aresetn pulsed mid-CAPTURE -> all outputs 0, busy 0, no output packet.

Source files
------------

// File: rtl/axis_adc_burst_capture.sv
`default_nettype none
// ============================================================================
// Module   : axis_adc_burst_capture
// Purpose  : Threshold-triggered burst capture of one ADC channel into block
//            RAM, drained as an AXI-Stream packet with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module axis_adc_burst_capture #(
    parameter int ADDR_WIDTH = 10,
    parameter int CHANNEL    = 0,
    parameter int CONFIRM    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  cfg_enable,
    input  logic [14:0]           cfg_threshold,
    input  logic [ADDR_WIDTH:0]   cfg_frame_len,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic [15:0]           missed_count
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);
    localparam logic [3:0]        CONFIRM_C = 4'(CONFIRM);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [15:0]           sample;
    logic [15:0]           abs_val;
    logic [14:0]           mag;
    logic                  above;
    logic                  sample_hit;
    logic                  cnt_hit;
    logic                  trigger;
    logic                  capture_done;
    logic                  last_ack;
    logic                  out_load;
    logic                  rd_en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   len_sel;

    logic [3:0]            confirm_cnt;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  s1_valid;
    logic                  s1_last;
    logic [15:0]           ram_q;
    logic [15:0]           mem [DEPTH];

    // Channel select and magnitude; -32768 folds onto 32767
    always_comb begin
        sample  = (CHANNEL == 0) ? s_axis_tdata[15:0] : s_axis_tdata[31:16];
        abs_val = sample[15] ? (~sample + 16'd1) : sample;
        mag     = abs_val[15] ? 15'h7FFF : abs_val[14:0];
        above   = (mag > cfg_threshold);
    end

    // Trigger, capture and drain handshake qualifiers
    always_comb begin
        sample_hit   = s_axis_tvalid && cfg_enable && above;
        cnt_hit      = (confirm_cnt == CONFIRM_C - 4'd1);
        trigger      = (state == S_IDLE) && sample_hit && cnt_hit;
        capture_done = (state == S_CAPTURE) && s_axis_tvalid && ((wr_ptr + ONE) == len);
        last_ack     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        out_load     = s1_valid && (!m_axis_tvalid || m_axis_tready);
        rd_en        = (state == S_DRAIN) && (rd_ptr != len) && (!s1_valid || out_load);
        we           = trigger || ((state == S_CAPTURE) && s_axis_tvalid);
        waddr        = trigger ? '0 : wr_ptr[ADDR_WIDTH-1:0];
        if (cfg_frame_len == '0) begin
            len_sel = ONE;
        end else if (cfg_frame_len > MAX_LEN) begin
            len_sel = MAX_LEN;
        end else begin
            len_sel = cfg_frame_len;
        end
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next = (len_sel == ONE) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (capture_done) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Confirm counter: arms triggers in IDLE, detects missed bursts in DRAIN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            confirm_cnt  <= '0;
            missed_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger || !cfg_enable) begin
                        confirm_cnt <= '0;
                    end else if (s_axis_tvalid) begin
                        confirm_cnt <= above ? confirm_cnt + 4'd1 : 4'd0;
                    end
                end
                S_DRAIN: begin
                    if (last_ack || !cfg_enable) begin
                        confirm_cnt <= '0;
                    end else if (s_axis_tvalid) begin
                        if (!above) begin
                            confirm_cnt <= '0;
                        end else if (confirm_cnt != CONFIRM_C) begin
                            confirm_cnt <= confirm_cnt + 4'd1;
                        end
                    end
                    // Count only the rising edge of the confirm condition
                    if (!last_ack && sample_hit && cnt_hit && missed_count != 16'hFFFF) begin
                        missed_count <= missed_count + 16'd1;
                    end
                end
                default: confirm_cnt <= '0;
            endcase
        end
    end

    // Frame length latch and write pointer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len    <= '0;
            wr_ptr <= '0;
        end else if (trigger) begin
            len    <= len_sel;
            wr_ptr <= ONE;
        end else if (state == S_CAPTURE && s_axis_tvalid) begin
            wr_ptr <= wr_ptr + ONE;
        end
    end

    // Capture buffer: one write port, one synchronous read port
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= sample;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // Read pointer and RAM-output valid stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            if (state != S_DRAIN) begin
                rd_ptr <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (rd_en) begin
                s1_valid <= 1'b1;
                s1_last  <= ((rd_ptr + ONE) == len);
            end else if (out_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // AXI-Stream output register, held while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ram_q;
            m_axis_tlast  <= s1_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    // Completed-frame counter, wraps
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
        end else if (last_ack) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_adc_burst_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_adc_burst_capture
// Purpose  : Directed self-checking bench for axis_adc_burst_capture
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_adc_burst_capture;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        cfg_enable = 1'b0;
    logic [14:0] cfg_threshold = '0;
    logic [10:0] cfg_frame_len = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] missed_count;

    int checks = 0;
    int failures = 0;

    logic [16:0] q[$];
    logic [16:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [16:0] held = '0;

    axis_adc_burst_capture #(
        .ADDR_WIDTH (10),
        .CHANNEL    (0),
        .CONFIRM    (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .cfg_enable    (cfg_enable),
        .cfg_threshold (cfg_threshold),
        .cfg_frame_len (cfg_frame_len),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_count   (frame_count),
        .missed_count  (missed_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Collect handshakes and verify stalled beats stay put (sampled mid-cycle)
    always @(negedge aclk) begin
        if (hold_pending) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            q.push_back({m_axis_tlast, m_axis_tdata});
        end
        hold_pending = m_axis_tvalid && !m_axis_tready && aresetn;
        held         = {m_axis_tlast, m_axis_tdata};
    end

    task automatic drive(input logic v, input logic [15:0] d);
        s_axis_tvalid = v;
        s_axis_tdata  = {16'h0000, d};
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Called right after the final capture write: tvalid must rise two edges later
    task automatic check_latency(input logic [15:0] first);
        s_axis_tvalid = 1'b0;
        check("lat_edge0", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        check("lat_edge1", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        check("lat_edge2", 32'(m_axis_tvalid), 32'd1);
        check("lat_first_data", 32'(m_axis_tdata), 32'(first));
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge aclk);
            #1;
            k++;
        end
        idle(3);
        check("xfer_count", 32'(q.size()), 32'(n));
    endtask

    task automatic compare_frame(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q.size()) begin
                check({tag, "_data"}, 32'(q[i][15:0]), 32'(exp_q[i]));
                check({tag, "_last"}, 32'(q[i][16]), (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        int errs;
        int lasts;
        logic seen;

        // Reset state
        idle(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_missed", 32'(missed_count), 32'd0);
        aresetn = 1'b1;
        idle(2);

        // Test 1: basic ramp trigger, len 8
        cfg_enable = 1'b1; cfg_threshold = 15'd1000; cfg_frame_len = 11'd8; m_axis_tready = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'd2000);
        drive(1'b1, 16'd500);
        for (int i = 0; i < 11; i++) drive(1'b1, 16'(1200 + i));
        check_latency(16'd1203);
        wait_xfers(8, 50);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(17'(1203 + i));
        compare_frame("t1");
        check("t1_frames", 32'(frame_count), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Test 2: -32768 with threshold 32766, len 0 -> single-sample frame
        cfg_threshold = 15'd32766; cfg_frame_len = 11'd0;
        q.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h8000);
        check_latency(16'h8000);
        wait_xfers(1, 20);
        exp_q.delete();
        exp_q.push_back(17'h08000);
        compare_frame("t2");
        check("t2_frames", 32'(frame_count), 32'd2);

        // Threshold 32767: -32768 never qualifies
        cfg_threshold = 15'd32767;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h8000);
            seen = seen | busy;
        end
        idle(3);
        check("t2_no_trigger", 32'(seen | busy), 32'd0);

        // Test 3: backpressure 1,0,0,1, len 16
        cfg_threshold = 15'd1000; cfg_frame_len = 11'd16; m_axis_tready = 1'b0;
        q.delete();
        for (int i = 0; i < 19; i++) drive(1'b1, 16'(3000 + i));
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 200 && q.size() < 16; k++) begin
            m_axis_tready = (k % 4 == 0 || k % 4 == 3);
            @(posedge aclk);
            #1;
        end
        m_axis_tready = 1'b1;
        idle(3);
        check("t3_count", 32'(q.size()), 32'd16);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(17'(3003 + i));
        compare_frame("t3");
        check("t3_frames", 32'(frame_count), 32'd3);

        // Test 4: intermittent input valid during capture
        cfg_frame_len = 11'd8;
        q.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd5000);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 16'd7777);
            drive(1'b0, 16'd7777);
            drive(1'b1, 16'(6000 + i));
        end
        check_latency(16'd5000);
        wait_xfers(8, 50);
        exp_q.delete();
        exp_q.push_back(17'd5000);
        for (int i = 1; i < 8; i++) exp_q.push_back(17'(6000 + i));
        compare_frame("t4");
        check("t4_frames", 32'(frame_count), 32'd4);

        // Test 5: burst during stalled drain -> one missed trigger
        m_axis_tready = 1'b0;
        q.delete();
        for (int i = 0; i < 11; i++) drive(1'b1, 16'd5000);
        for (int i = 0; i < 10; i++) drive(1'b1, 16'd5000);
        idle(90);
        check("t5_missed", 32'(missed_count), 32'd1);
        check("t5_frames_held", 32'(frame_count), 32'd4);
        check("t5_busy", 32'(busy), 32'd1);
        m_axis_tready = 1'b1;
        wait_xfers(8, 50);
        check("t5_frames", 32'(frame_count), 32'd5);
        check("t5_missed_after", 32'(missed_count), 32'd1);

        // Confirm restarts from zero in IDLE; then reset mid-capture
        for (int i = 0; i < 3; i++) drive(1'b1, 16'd5000);
        check("t5_not_yet", 32'(busy), 32'd0);
        drive(1'b1, 16'd5000);
        check("t5_retrigger", 32'(busy), 32'd1);
        drive(1'b1, 16'd5000);
        drive(1'b1, 16'd5000);
        q.delete();
        aresetn = 1'b0;
        idle(2);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_frames", 32'(frame_count), 32'd0);
        check("mid_rst_missed", 32'(missed_count), 32'd0);
        aresetn = 1'b1;
        idle(30);
        check("mid_rst_no_pkt", 32'(q.size()), 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);

        // Test 6: len 2000 clamps to 1024
        cfg_threshold = 15'd10; cfg_frame_len = 11'd2000;
        q.delete();
        for (int i = 0; i < 1027; i++) drive(1'b1, 16'(100 + i));
        s_axis_tvalid = 1'b0;
        wait_xfers(1024, 1200);
        errs = 0;
        lasts = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][15:0] !== 16'(103 + i)) errs++;
            if (q[i][16]) lasts++;
        end
        check("t6_order_errs", 32'(errs), 32'd0);
        check("t6_tlast_count", 32'(lasts), 32'd1);
        if (q.size() == 1024) check("t6_tlast_pos", 32'(q[1023][16]), 32'd1);
        check("t6_frames", 32'(frame_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
